// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR envelope generator driven by a note gate, stepped once per prescaler tick
// Define ADSR_RETRIG_EN for hard retrigger (level forced to 0 on a re-press); default build is legato.
module adsr_envelope #(
  parameter int WIDTH    = 24,
  parameter int RATE_W   = 16,
  parameter int PRESCALE = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_gate,
  input  logic [RATE_W-1:0] i_attack_rate,
  input  logic [RATE_W-1:0] i_decay_rate,
  input  logic [WIDTH-1:0]  i_sustain_level,
  input  logic [RATE_W-1:0] i_release_rate,
  output logic [WIDTH-1:0]  o_level,
  output logic [2:0]        o_stage,
  output logic              o_active
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW    = ((RATE_W > WIDTH) ? RATE_W : WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] LVL_MAX  = {WIDTH{1'b1}};
  localparam logic [AW-1:0]    LVL_MAX_X = {{(AW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

  logic [CNT_W-1:0] cnt_q;
  logic             gate_q;
  stage_e           stage_q;
  logic [WIDTH-1:0] level_q;
  logic             active_q;

  logic             tick;
  logic             rise;
  logic             fall;
  logic [AW-1:0]    level_x;
  logic [AW-1:0]    sus_x;
  logic [AW-1:0]    atk_x;
  logic [AW-1:0]    dec_x;
  logic [AW-1:0]    rel_x;
  logic [AW-1:0]    att_sum;
  logic [WIDTH-1:0] att_d;
  logic [WIDTH-1:0] dec_d;
  logic [WIDTH-1:0] rel_d;

  assign tick = (cnt_q == CNT_LAST);
  assign rise = i_gate & ~gate_q;
  assign fall = ~i_gate & gate_q;

  // Widened arithmetic so saturation and floor clamps are exact compares, never wraps.
  always_comb begin
    level_x = {{(AW-WIDTH){1'b0}}, level_q};
    sus_x   = {{(AW-WIDTH){1'b0}}, i_sustain_level};
    atk_x   = {{(AW-RATE_W){1'b0}}, i_attack_rate};
    dec_x   = {{(AW-RATE_W){1'b0}}, i_decay_rate};
    rel_x   = {{(AW-RATE_W){1'b0}}, i_release_rate};
    att_sum = level_x + atk_x;
    att_d   = (att_sum >= LVL_MAX_X) ? LVL_MAX : att_sum[WIDTH-1:0];
    if (level_x >= sus_x + dec_x) begin
      dec_d = level_q - dec_x[WIDTH-1:0];
    end else begin
      dec_d = i_sustain_level;
    end
    if (level_x > rel_x) begin
      rel_d = level_q - rel_x[WIDTH-1:0];
    end else begin
      rel_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      gate_q   <= 1'b0;
      stage_q  <= ST_IDLE;
      level_q  <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
      gate_q <= i_gate;
      if (rise) begin
        stage_q  <= ST_ATTACK;
        active_q <= 1'b1;
`ifdef ADSR_RETRIG_EN
        if (stage_q != ST_IDLE) begin
          level_q <= '0;
        end
`else
        level_q  <= level_q;
`endif
      end else if (fall && (stage_q == ST_ATTACK || stage_q == ST_DECAY ||
                            stage_q == ST_SUSTAIN)) begin
        stage_q  <= ST_RELEASE;
        active_q <= 1'b1;
      end else if (tick) begin
        case (stage_q)
          ST_ATTACK: begin
            level_q <= att_d;
            if (att_d == LVL_MAX) begin
              stage_q <= ST_DECAY;
            end
          end
          ST_DECAY: begin
            level_q <= dec_d;
            if (dec_d == i_sustain_level) begin
              stage_q <= ST_SUSTAIN;
            end
          end
          ST_SUSTAIN: begin
            level_q <= i_sustain_level;
          end
          ST_RELEASE: begin
            level_q <= rel_d;
            if (rel_d == '0) begin
              stage_q  <= ST_IDLE;
              active_q <= 1'b0;
            end
          end
          default: begin
            level_q <= level_q;
          end
        endcase
      end
    end
  end

  assign o_level  = level_q;
  assign o_stage  = stage_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - scoreboard bench for adsr_envelope (WIDTH=8, RATE_W=8, PRESCALE=4)
module tb_adsr_envelope;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate  = 1'b0;
  logic [7:0] atk   = 8'd64;
  logic [7:0] dec   = 8'd32;
  logic [7:0] rel   = 8'd50;
  logic [7:0] sus   = 8'd100;
  logic [7:0] level;
  logic [2:0] stage;
  logic       active;

  int total = 0;
  int bad   = 0;
  logic [11:0] expq[$];

  always #5 clk = ~clk;

  adsr_envelope #(.WIDTH(8), .RATE_W(8), .PRESCALE(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_gate          (gate),
    .i_attack_rate   (atk),
    .i_decay_rate    (dec),
    .i_sustain_level (sus),
    .i_release_rate  (rel),
    .o_level         (level),
    .o_stage         (stage),
    .o_active        (active)
  );

  task automatic ex(input logic [2:0] st, input logic [7:0] lv);
    expq.push_back({(st != 3'd0), st, lv});
  endtask

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got act=%0d stage=%0d level=%0d want act=%0d stage=%0d level=%0d",
               nm, got[11], got[10:8], got[7:0], want[11], want[10:8], want[7:0]);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain_%s: got %0d pending outputs want 0", nm, expq.size());
      expq.delete();
    end
  endtask

  task automatic wait_for(input string nm, input logic [2:0] st, input logic [7:0] lv);
    int n;
    n = 0;
    while (!(stage == st && level == lv) && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_%s: got stage=%0d level=%0d want stage=%0d level=%0d",
               nm, stage, level, st, lv);
    end
  endtask

  task automatic push_attack_decay_to_100();
    ex(3'd1, 8'd0);   ex(3'd1, 8'd64);  ex(3'd1, 8'd128); ex(3'd1, 8'd192);
    ex(3'd2, 8'd255); ex(3'd2, 8'd223); ex(3'd2, 8'd191); ex(3'd2, 8'd159);
    ex(3'd2, 8'd127); ex(3'd3, 8'd100);
  endtask

  // Monitor: every change of the output tuple consumes one expected entry.
  initial begin
    logic [11:0] cur;
    logic [11:0] prev;
    logic [11:0] want;
    bit          first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = {active, stage, level};
      if (first || cur != prev) begin
        first = 1'b0;
        prev  = cur;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected: got act=%0d stage=%0d level=%0d want no change",
                   cur[11], cur[10:8], cur[7:0]);
        end else begin
          want = expq.pop_front();
          chk("mon", cur, want);
        end
      end
    end
  end

  initial begin
    ex(3'd0, 8'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    drain("reset");
    repeat (2) @(posedge clk);
    #3;

    gate = 1'b1;
    push_attack_decay_to_100();
    drain("attack_decay");

    repeat (6) @(posedge clk);
    #3 gate = 1'b0;
    ex(3'd4, 8'd100); ex(3'd4, 8'd50); ex(3'd0, 8'd0);
    drain("release");

    gate = 1'b1;
    push_attack_decay_to_100();
    drain("attack_decay2");
    repeat (3) @(posedge clk);
    #3 sus = 8'd40;
    ex(3'd3, 8'd40);
    drain("sustain_track");
    repeat (10) @(posedge clk);
    #3 gate = 1'b0;
    ex(3'd4, 8'd40); ex(3'd0, 8'd0);
    drain("release40");
    sus = 8'd100;

    gate = 1'b1;
    ex(3'd1, 8'd0); ex(3'd1, 8'd64); ex(3'd1, 8'd128);
    wait_for("att128", 3'd1, 8'd128);
    gate = 1'b0;
    ex(3'd4, 8'd128); ex(3'd4, 8'd78);
    wait_for("rel78", 3'd4, 8'd78);
    gate = 1'b1;
`ifdef ADSR_RETRIG_EN
    ex(3'd1, 8'd0); ex(3'd1, 8'd64); ex(3'd1, 8'd128); ex(3'd1, 8'd192);
`else
    ex(3'd1, 8'd78); ex(3'd1, 8'd142); ex(3'd1, 8'd206);
`endif
    ex(3'd2, 8'd255); ex(3'd2, 8'd223); ex(3'd2, 8'd191); ex(3'd2, 8'd159);
    ex(3'd2, 8'd127); ex(3'd3, 8'd100);
    drain("retrigger");
    gate = 1'b0;
    ex(3'd4, 8'd100); ex(3'd4, 8'd50); ex(3'd0, 8'd0);
    drain("release3");

    atk  = 8'd0;
    gate = 1'b1;
    ex(3'd1, 8'd0);
    drain("atk0_enter");
    repeat (400) @(posedge clk);
    #3 chk("atk0_hold", {active, stage, level}, {1'b1, 3'd1, 8'd0});
    gate = 1'b0;
    ex(3'd4, 8'd0); ex(3'd0, 8'd0);
    drain("atk0_release");
    atk = 8'd64;

    sus  = 8'd255;
    gate = 1'b1;
    ex(3'd1, 8'd0); ex(3'd1, 8'd64); ex(3'd1, 8'd128); ex(3'd1, 8'd192);
    ex(3'd2, 8'd255); ex(3'd3, 8'd255);
    drain("sus_max");
    gate = 1'b0;
    ex(3'd4, 8'd255); ex(3'd4, 8'd205); ex(3'd4, 8'd155); ex(3'd4, 8'd105);
    ex(3'd4, 8'd55);  ex(3'd4, 8'd5);   ex(3'd0, 8'd0);
    drain("sus_max_release");
    sus = 8'd100;

    gate = 1'b1;
    ex(3'd1, 8'd0); ex(3'd1, 8'd64); ex(3'd1, 8'd128); ex(3'd1, 8'd192);
    ex(3'd2, 8'd255); ex(3'd2, 8'd223);
    wait_for("dec223", 3'd2, 8'd223);
    @(posedge clk);
    #2;
    ex(3'd0, 8'd0);
    rst_n = 1'b0;
    #1 chk("async_reset", {active, stage, level}, 12'h000);
    gate = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain("async_reset");
    repeat (20) @(posedge clk);
    #3 chk("idle_after_reset", {active, stage, level}, 12'h000);
    gate = 1'b1;
    ex(3'd1, 8'd0); ex(3'd1, 8'd64);
    wait_for("att64", 3'd1, 8'd64);
    gate = 1'b0;
    ex(3'd4, 8'd64); ex(3'd4, 8'd14); ex(3'd0, 8'd0);
    drain("final_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
